// File: rtl/sweep_ctrl.sv
// Triangle-sweep sequencer for a loadable up/down counter: loads lo, sweeps up to hi and back, n times.
// Optional dwell at each limit when SWEEP_HOLD_EN is defined (HOLD_CYC cycles per dwell).
module sweep_ctrl #(
  parameter int WIDTH    = 4,
  parameter int SWEEPS_W = 4
`ifdef SWEEP_HOLD_EN
  ,
  parameter int HOLD_CYC = 2
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    lo_lim,
  input  logic [WIDTH-1:0]    hi_lim,
  input  logic [SWEEPS_W-1:0] n_sweeps,
  input  logic [WIDTH-1:0]    count,
  output logic                load,
  output logic [WIDTH-1:0]    load_val,
  output logic                cnt_en,
  output logic                up_down_bar,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [SWEEPS_W-1:0] sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_UP, S_DOWN, S_DONE, S_HOLD_HI, S_HOLD_LO
  } state_t;

  state_t              state, nxt;
  logic [WIDTH-1:0]    hi_q;
  logic [SWEEPS_W-1:0] n_q;
  logic                req, legal, accept, reject;
  logic                at_top, at_bot, last_sweep;

  // load_val doubles as the latched low limit.
  assign req        = (state == S_IDLE) && start && !abort;
  assign legal      = (lo_lim < hi_lim) && (n_sweeps != '0);
  assign accept     = req && legal;
  assign reject     = req && !legal;

  // Turn one count early: the counter still steps on the edge that changes state.
  assign at_top     = count >= (hi_q - WIDTH'(1));
  assign at_bot     = count <= (load_val + WIDTH'(1));
  assign last_sweep = (sweep_cnt + SWEEPS_W'(1)) == n_q;

`ifdef SWEEP_HOLD_EN
  localparam int     HOLD_EFF = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
  localparam int     HOLD_W   = $clog2(HOLD_EFF + 1);
  localparam state_t TURN_HI  = S_HOLD_HI;
  localparam state_t TURN_LO  = S_HOLD_LO;

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_end;

  assign hold_end = (hold_cnt == '0);

  // Reloaded on every state change, so it is primed on entry to either dwell.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              hold_cnt <= '0;
    else if (nxt != state) hold_cnt <= HOLD_W'(HOLD_EFF - 1);
    else if (!hold_end)    hold_cnt <= hold_cnt - 1'b1;
  end
`else
  localparam state_t TURN_HI = S_DOWN;
  localparam state_t TURN_LO = S_UP;
`endif

  always_comb begin
    // NOTE: nxt gets a default before any branch, so no path leaves it unassigned (no latch).
    nxt = state;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (accept) nxt = S_LOAD;
        S_LOAD:    nxt = S_UP;
        S_UP:      if (at_top) nxt = TURN_HI;
        S_DOWN:    if (at_bot) nxt = last_sweep ? S_DONE : TURN_LO;
`ifdef SWEEP_HOLD_EN
        S_HOLD_HI: if (hold_end) nxt = S_DOWN;
        S_HOLD_LO: if (hold_end) nxt = S_UP;
`endif
        default:   nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered decodes of the state being entered, so they always match state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      hi_q        <= '0;
      n_q         <= '0;
      load_val    <= '0;
      sweep_cnt   <= '0;
      load        <= 1'b0;
      cnt_en      <= 1'b0;
      up_down_bar <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here, so every register sees the pre-edge values of the others.
      state       <= nxt;
      load        <= (nxt == S_LOAD);
      cnt_en      <= (nxt == S_UP) || (nxt == S_DOWN);
      up_down_bar <= (nxt == S_UP);
      busy        <= (nxt != S_IDLE) && (nxt != S_DONE);
      done        <= (nxt == S_DONE);
      err         <= reject;
      if (accept) begin
        load_val  <= lo_lim;
        hi_q      <= hi_lim;
        n_q       <= n_sweeps;
        sweep_cnt <= '0;
      end else if ((state == S_DOWN) && at_bot && !abort) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: a behavioural counter closes the loop, a triangle model predicts
// the count trajectory and the load/done/err pulses, and a negedge monitor compares them.
module tb_sweep_ctrl;

  localparam int W  = 4;
  localparam int SW = 4;
`ifdef SWEEP_HOLD_EN
  localparam int H = 2;
`else
  localparam int H = 0;
`endif

  typedef enum int {EV_LOAD, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e     kind;
    int           cyc;
    logic [W-1:0] val;
    logic [SW-1:0] scnt;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  lo_lim = '0;
  logic [W-1:0]  hi_lim = '0;
  logic [SW-1:0] n_sweeps = '0;
  logic [W-1:0]  count;
  logic [W-1:0]  load_val;
  logic [SW-1:0] sweep_cnt;
  logic          load, cnt_en, up_down_bar, busy, done, err;

  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  ev_t           ev_q[$];
  logic [W-1:0]  traj_q[$];
  int            traj_start = 0;
  int            run_cd = 0;
  logic [SW-1:0] last_scnt = '0;

  sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .n_sweeps(n_sweeps), .count(count),
    .load(load), .load_val(load_val), .cnt_en(cnt_en), .up_down_bar(up_down_bar),
    .busy(busy), .done(done), .err(err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The loadable up/down counter the sequencer steers.
  always @(posedge clk or negedge rst) begin
    if (!rst)        count <= '0;
    else if (load)   count <= load_val;
    else if (cnt_en) count <= up_down_bar ? count + 1'b1 : count - 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic take(input ev_kind_e k);
    ev_t e;
    if (ev_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious_%s: pulse at cycle %0d, expected none", k.name(), cyc);
    end else begin
      e = ev_q.pop_front();
      check("event_kind", k, e.kind);
      check("event_cycle", cyc, e.cyc);
      check("busy_at_event", busy, k == EV_LOAD);
      if (k == EV_LOAD) check("load_val", load_val, e.val);
      else              check("sweep_cnt_at_event", sweep_cnt, e.scnt);
      if (k == EV_DONE) check("count_at_done", count, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (traj_q.size() > 0 && cyc >= traj_start) check("count_traj", count, traj_q.pop_front());
      if (load) take(EV_LOAD);
      if (err)  take(EV_ERR);
      if (done) take(EV_DONE);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Count seen each cycle from the load onwards: lo, up to hi, dwell, down to lo, dwell, ...
  task automatic build_traj(input int lo, input int hi, input int n);
    traj_q.push_back(W'(lo));
    for (int s = 1; s <= n; s++) begin
      for (int v = lo + 1; v <= hi; v++) traj_q.push_back(W'(v));
      repeat (H) traj_q.push_back(W'(hi));
      for (int v = hi - 1; v >= lo; v--) traj_q.push_back(W'(v));
      if (s < n) repeat (H) traj_q.push_back(W'(lo));
    end
  endtask

  task automatic issue(input int lo, input int hi, input int n);
    ev_t e;
    lo_lim   = W'(lo);
    hi_lim   = W'(hi);
    n_sweeps = SW'(n);
    start    = 1'b1;
    if (lo < hi && n != 0) begin
      e.kind = EV_LOAD; e.cyc = cyc + 1; e.val = W'(lo); e.scnt = '0;
      ev_q.push_back(e);
      e.kind = EV_DONE; e.cyc = cyc + 2 + 2 * (hi - lo) * n + (2 * n - 1) * H; e.scnt = SW'(n);
      ev_q.push_back(e);
      run_cd     = cyc;
      traj_start = cyc + 2;
      build_traj(lo, hi, n);
      last_scnt  = SW'(n);
    end else begin
      e.kind = EV_ERR; e.cyc = cyc + 1; e.val = '0; e.scnt = last_scnt;
      ev_q.push_back(e);
    end
    tick();
    start    = 1'b0;
    lo_lim   = W'($urandom);
    hi_lim   = W'($urandom);
    n_sweeps = SW'($urandom);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (ev_q.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    if (ev_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d events outstanding, expected 0", ev_q.size());
      ev_q.delete();
      traj_q.delete();
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lo, d, n, c_abort, exp_s;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", {load, cnt_en, up_down_bar, busy, done, err, load_val, sweep_cnt}, '0);
    rst = 1'b1;
    tick();

    issue(2, 5, 1);   drain(200);
    check("rest_count", count, 2);
    check("sweep_cnt_hold", sweep_cnt, 1);
    issue(0, 15, 3);  drain(400);
    issue(7, 7, 1);   drain(20);
    issue(3, 9, 0);   drain(20);
    issue(6, 7, 2);   drain(60);
    issue(14, 15, 1); drain(60);

    // abort and a legal start in the same IDLE cycle: nothing may start
    lo_lim = 1; hi_lim = 4; n_sweeps = 1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check("abort_beats_start", busy, 1'b0);

    // abort in the down leg of sweep 2 of 4, with an ignored start while busy
    lo = $urandom_range(0, 10);
    d  = $urandom_range(2, 5);
    issue(lo, lo + d, 4);
    lo_lim = 0; hi_lim = 15; n_sweeps = 1; start = 1'b1;
    tick();
    start = 1'b0;
    c_abort = run_cd + 2 + 3 * d + 3 * H + int'($urandom_range(0, d - 1));
    while (cyc < c_abort) tick();
    abort = 1'b1;
    while (traj_q.size() > 2) void'(traj_q.pop_back());
    for (int i = ev_q.size() - 1; i >= 0; i--) if (ev_q[i].kind == EV_DONE) ev_q.delete(i);
    exp_s = 0;
    for (int i = 1; i <= 4; i++) if (run_cd + 2 + 2 * d * i + (2 * i - 1) * H <= c_abort) exp_s++;
    last_scnt = SW'(exp_s);
    tick();
    abort = 1'b0;
    check("abort_cnt_en", cnt_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_sweep_cnt", sweep_cnt, exp_s);
    repeat (2 * d + 4) tick();
    check("abort_stays_idle", busy, 1'b0);

    // asynchronous reset in the middle of a run, then a fresh run
    issue(1, 12, 2);
    repeat ($urandom_range(3, 30)) tick();
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {load, cnt_en, up_down_bar, busy, done, err, load_val, sweep_cnt}, '0);
    ev_q.delete();
    traj_q.delete();
    last_scnt = '0;
    tick();
    rst = 1'b1;
    tick();
    issue(4, 9, 1); drain(100);

    for (int k = 0; k < 12; k++) begin
      lo = $urandom_range(0, 14);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) issue(lo, $urandom_range(0, lo), $urandom_range(1, 4));
        else                           issue(lo, lo + int'($urandom_range(1, 15 - lo)), 0);
      end else begin
        d = $urandom_range(1, 15 - lo);
        n = $urandom_range(1, 4);
        issue(lo, lo + d, n);
      end
      drain(600);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
